// File: rtl/spi_arb_if.sv
// rtl/spi_arb_if.sv - requester, SPI-master and status signals shared by spi_arb and its environment
interface spi_arb_if;
  logic        req_inrt;
  logic [15:0] cmd_inrt;
  logic        req_batt;
  logic [15:0] cmd_batt;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic        ss_sel;
  logic        busy;
  logic        ack_inrt;
  logic        ack_batt;
  logic [15:0] rd_data;
  logic        timeout;

  modport slave (
    input  req_inrt, cmd_inrt, req_batt, cmd_batt, spi_done, spi_rd,
    output spi_wrt, spi_cmd, ss_sel, busy, ack_inrt, ack_batt, rd_data, timeout
  );

  modport master (
    output req_inrt, cmd_inrt, req_batt, cmd_batt, spi_done, spi_rd,
    input  spi_wrt, spi_cmd, ss_sel, busy, ack_inrt, ack_batt, rd_data, timeout
  );
endinterface

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - two-requester arbiter for one shared 16-bit SPI master
// Inertial has priority; battery is forced through after MAX_CONSEC inertial grants.
module spi_arb #(
  parameter int MAX_CONSEC = 4,
  parameter int TO_CYCLES  = 2048
) (
  input  logic     i_clk,
  input  logic     i_rst,
  spi_arb_if.slave bus
);
  localparam int CW = $clog2(MAX_CONSEC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_timeout;
  logic [15:0]   r_spi_cmd;
  logic [15:0]   r_rd_data;
  logic [CW-1:0] r_consec;
  logic [11:0]   r_wait_cnt;
  logic          w_any_req;
  logic          w_batt_wins;
  logic          w_last_cnt;
  logic          w_timeout;

  assign w_any_req   = bus.req_inrt | bus.req_batt;
  assign w_batt_wins = bus.req_batt & (~bus.req_inrt | (r_consec == CW'(MAX_CONSEC)));
  assign w_last_cnt  = (r_wait_cnt == 12'(TO_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // spi_done is only looked at in WAIT and beats a simultaneous final count
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:  if (w_any_req) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (bus.spi_done) begin
          w_next = RESP;
        end else if (w_last_cnt) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner    <= 1'b0;
      r_timeout  <= 1'b0;
      r_spi_cmd  <= 16'h0000;
      r_rd_data  <= 16'h0000;
      r_consec   <= '0;
      r_wait_cnt <= 12'd0;
    end else begin
      r_timeout <= w_timeout;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_batt_wins;
            r_spi_cmd <= w_batt_wins ? bus.cmd_batt : bus.cmd_inrt;
            if (w_batt_wins || !bus.req_batt)
              r_consec <= '0;
            else if (r_consec != CW'(MAX_CONSEC))
              r_consec <= r_consec + 1'b1;
          end
        end
        ISSUE: r_wait_cnt <= 12'd0;
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 12'd1;
          if (bus.spi_done) r_rd_data <= bus.spi_rd;
        end
        default: ;
      endcase
    end
  end

  assign bus.spi_wrt  = (r_state == ISSUE);
  assign bus.busy     = (r_state != IDLE);
  assign bus.ack_inrt = (r_state == RESP) & ~r_owner;
  assign bus.ack_batt = (r_state == RESP) & r_owner;
  assign bus.spi_cmd  = r_spi_cmd;
  assign bus.ss_sel   = r_owner;
  assign bus.rd_data  = r_rd_data;
  assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - directed self-checking bench for spi_arb
module tb_spi_arb;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_arb_if bus();

  spi_arb #(.MAX_CONSEC(4), .TO_CYCLES(2048)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrt(input string tag);
    int n = 0;
    while (!bus.spi_wrt && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_wrt_seen"}, bus.spi_wrt, 1);
  endtask

  // Entered in ISSUE or WAIT; leaves the bench in the RESP cycle.
  task automatic finish_txn(input string tag, input bit batt, input logic [15:0] cmd,
                            input int dly, input logic [15:0] rd);
    check({tag, "_ss_sel"}, bus.ss_sel, batt);
    check({tag, "_spi_cmd"}, bus.spi_cmd, cmd);
    repeat (dly) tick();
    bus.spi_done = 1'b1;
    bus.spi_rd   = rd;
    tick();
    bus.spi_done = 1'b0;
    bus.spi_rd   = 16'hDEAD;
    check({tag, "_ack_inrt"}, bus.ack_inrt, !batt);
    check({tag, "_ack_batt"}, bus.ack_batt, batt);
    check({tag, "_rd_data"}, bus.rd_data, rd);
    check({tag, "_cmd_hold"}, bus.spi_cmd, cmd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst          = 1'b1;
    bus.req_inrt = 1'b0;
    bus.req_batt = 1'b0;
    bus.cmd_inrt = 16'h0000;
    bus.cmd_batt = 16'h0000;
    bus.spi_done = 1'b0;
    bus.spi_rd   = 16'h0000;
    tick();
    tick();
    check("rst_spi_wrt", bus.spi_wrt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ss_sel", bus.ss_sel, 0);
    check("rst_spi_cmd", bus.spi_cmd, 16'h0000);
    check("rst_rd_data", bus.rd_data, 16'h0000);
    check("rst_acks", {bus.ack_inrt, bus.ack_batt}, 2'b00);
    check("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", bus.busy, 0);

    // single inertial transaction, cmd changed after grant
    bus.req_inrt = 1'b1;
    bus.cmd_inrt = 16'hA255;
    tick();
    check("t40_latency", bus.spi_wrt, 1);
    check("t40_busy", bus.busy, 1);
    bus.cmd_inrt = 16'h0000;
    finish_txn("t40", 1'b0, 16'hA255, 40, 16'h1234);
    bus.req_inrt = 1'b0;
    tick();
    check("t40_idle_busy", bus.busy, 0);
    check("t40_ack_off", bus.ack_inrt, 0);

    // both held: I,I,I,I,B repeating
    bus.req_inrt = 1'b1;
    bus.req_batt = 1'b1;
    bus.cmd_inrt = 16'h1111;
    bus.cmd_batt = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      bit exp_b;
      exp_b = (i % 5 == 4);
      wait_wrt($sformatf("arb%0d", i));
      finish_txn($sformatf("arb%0d", i), exp_b, exp_b ? 16'h2222 : 16'h1111, 3,
                 16'h0100 + 16'(i));
    end
    bus.req_inrt = 1'b0;
    bus.req_batt = 1'b0;
    tick();

    // stray done in IDLE
    bus.spi_done = 1'b1;
    bus.spi_rd   = 16'hFFFF;
    tick();
    bus.spi_done = 1'b0;
    check("t43_stray_busy", bus.busy, 0);
    check("t43_stray_rd", bus.rd_data, 16'h0109);
    tick();
    check("t43_stray_acks", {bus.ack_inrt, bus.ack_batt}, 2'b00);
    bus.req_batt = 1'b1;
    bus.cmd_batt = 16'hC3A0;
    wait_wrt("t43");
    finish_txn("t43", 1'b1, 16'hC3A0, 5, 16'h0C80);
    bus.req_batt = 1'b0;
    tick();

    // timeout with no done, then re-grant
    bus.req_batt = 1'b1;
    bus.cmd_batt = 16'h5A5A;
    wait_wrt("t42");
    seen = 1'b0;
    repeat (2048) begin
      tick();
      if (bus.timeout || bus.ack_batt || bus.ack_inrt || bus.spi_wrt) seen = 1'b1;
    end
    check("t42_early_pulse", seen, 0);
    check("t42_still_wait", bus.busy, 1);
    tick();
    check("t42_timeout", bus.timeout, 1);
    check("t42_idle", bus.busy, 0);
    check("t42_no_ack", bus.ack_batt, 0);
    check("t42_rd_keep", bus.rd_data, 16'h0C80);
    tick();
    check("t42_timeout_1cyc", bus.timeout, 0);
    check("t42_regrant", bus.spi_wrt, 1);
    finish_txn("t42r", 1'b1, 16'h5A5A, 2, 16'h7777);
    bus.req_batt = 1'b0;
    tick();

    // done coincident with final count
    bus.req_inrt = 1'b1;
    bus.cmd_inrt = 16'h0BEE;
    wait_wrt("tlast");
    repeat (2048) tick();
    bus.spi_done = 1'b1;
    bus.spi_rd   = 16'h4321;
    tick();
    bus.spi_done = 1'b0;
    check("tlast_no_to", bus.timeout, 0);
    check("tlast_ack", bus.ack_inrt, 1);
    check("tlast_rd", bus.rd_data, 16'h4321);
    bus.req_inrt = 1'b0;
    tick();
    check("tlast_no_to2", bus.timeout, 0);
    check("tlast_idle", bus.busy, 0);

    // request dropped in WAIT
    bus.req_inrt = 1'b1;
    bus.cmd_inrt = 16'h3C3C;
    wait_wrt("t45");
    tick();
    bus.req_inrt = 1'b0;
    repeat (3) tick();
    finish_txn("t45", 1'b0, 16'h3C3C, 1, 16'h0045);
    tick();
    check("t45_idle", bus.busy, 0);
    check("t45_ack_off", bus.ack_inrt, 0);

    // async reset in WAIT, then normal arbitration
    bus.req_batt = 1'b1;
    bus.cmd_batt = 16'h9999;
    bus.cmd_inrt = 16'h6666;
    wait_wrt("t44");
    tick();
    tick();
    check("t44_in_wait", bus.busy, 1);
    bus.req_inrt = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t44_busy", bus.busy, 0);
    check("t44_ss_sel", bus.ss_sel, 0);
    check("t44_spi_cmd", bus.spi_cmd, 16'h0000);
    check("t44_rd_data", bus.rd_data, 16'h0000);
    check("t44_outs", {bus.spi_wrt, bus.ack_inrt, bus.ack_batt, bus.timeout}, 4'b0000);
    tick();
    check("t44_held", bus.busy, 0);
    rst = 1'b0;
    tick();
    check("t44_latency", bus.spi_wrt, 1);
    check("t44_no_to", bus.timeout, 0);
    finish_txn("t44", 1'b0, 16'h6666, 2, 16'hA5A5);
    bus.req_inrt = 1'b0;
    bus.req_batt = 1'b0;
    tick();
    check("t44_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
